// File: rtl/complex_matrix_operand_loader.sv
//==============================================================================
// Module   : complex_matrix_operand_loader
// Brief    : Assembles 64-bit operand beats into ping-ponged matrix banks and
//            presents each complete matrix on a wide valid/ready port.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module complex_matrix_operand_loader #(
    parameter int SIZE   = 16,
    parameter int DATA_W = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [DATA_W-1:0]          s_data_i,
    input  logic                       s_valid_i,
    input  logic                       s_last_i,
    input  logic                       s_sub_i,
    output logic                       s_ready_o,
    output logic [4*SIZE*DATA_W-1:0]   operands_o,
    output logic                       sub_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    input  logic                       flush_i,
    output logic                       err_o,
    output logic                       busy_o
);

    localparam int NW    = 4 * SIZE;
    localparam int CNT_W = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NW - 1);

    logic [NW*DATA_W-1:0] bank_q [2];
    logic [1:0]           full_q;
    logic [1:0]           sub_q;
    logic                 wr_bank_q;
    logic                 rd_bank_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 err_q;

    logic                 w_accept;
    logic                 w_drain;

    assign s_ready_o   = !full_q[wr_bank_q];
    assign out_valid_o = full_q[rd_bank_q];
    assign operands_o  = bank_q[rd_bank_q];
    assign sub_o       = sub_q[rd_bank_q];
    assign err_o       = err_q;
    assign busy_o      = full_q[0] | full_q[1] | (cnt_q != '0);

    assign w_accept = s_valid_i && s_ready_o;
    assign w_drain  = out_valid_o && out_ready_i;

    // An accept needs full[wr]==0 and a drain needs full[rd]==1, so when both
    // fire in one cycle they always address different banks.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bank_q[0] <= '0;
            bank_q[1] <= '0;
            full_q    <= '0;
            sub_q     <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else if (flush_i) begin
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (w_accept) begin
                bank_q[wr_bank_q][int'(cnt_q)*DATA_W +: DATA_W] <= s_data_i;
                if (cnt_q == '0) begin
                    sub_q[wr_bank_q] <= s_sub_i;
                end
                if (cnt_q == LAST_CNT) begin
                    // A missing last still completes the frame; only flag it.
                    full_q[wr_bank_q] <= 1'b1;
                    wr_bank_q         <= ~wr_bank_q;
                    cnt_q             <= '0;
                    err_q             <= !s_last_i;
                end else if (s_last_i) begin
                    cnt_q <= '0;
                    err_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
            if (w_drain) begin
                full_q[rd_bank_q] <= 1'b0;
                rd_bank_q         <= ~rd_bank_q;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_complex_matrix_operand_loader.sv
//==============================================================================
// Module   : tb_complex_matrix_operand_loader
// Brief    : Directed, table-driven self-checking bench for the operand loader.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_complex_matrix_operand_loader;

    localparam int SIZE   = 2;
    localparam int DATA_W = 64;
    localparam int NW     = 4 * SIZE;

    logic                   clk_i = 1'b0;
    logic                   rst_i;
    logic [DATA_W-1:0]      s_data_i;
    logic                   s_valid_i;
    logic                   s_last_i;
    logic                   s_sub_i;
    logic                   s_ready_o;
    logic [NW*DATA_W-1:0]   operands_o;
    logic                   sub_o;
    logic                   out_valid_o;
    logic                   out_ready_i;
    logic                   flush_i;
    logic                   err_o;
    logic                   busy_o;

    int n_tests = 0;
    int n_fail  = 0;

    complex_matrix_operand_loader #(.SIZE(SIZE), .DATA_W(DATA_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_last_i(s_last_i),
        .s_sub_i(s_sub_i), .s_ready_o(s_ready_o),
        .operands_o(operands_o), .sub_o(sub_o), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .flush_i(flush_i),
        .err_o(err_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       name;
        int          nwords;
        int          last_idx;   // -1: s_last_i never asserted
        bit          sub;
        logic [63:0] base;
        bit          exp_valid;
        bit          exp_err;
    } frame_t;

    frame_t frames [5];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] opw(input int k);
        return operands_o[k*DATA_W +: DATA_W];
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Presents one beat and holds it until accepted, with a bounded wait.
    task automatic send_word(input logic [63:0] d, input bit last, input bit sub);
        int waited = 0;
        s_data_i  = d;
        s_last_i  = last;
        s_sub_i   = sub;
        s_valid_i = 1'b1;
        while (!s_ready_o && waited < 50) begin
            step();
            waited++;
        end
        if (!s_ready_o) begin
            check("send_word_timeout", 64'(s_ready_o), 64'd1);
        end else begin
            step();
        end
        s_valid_i = 1'b0;
        s_last_i  = 1'b0;
        s_sub_i   = 1'b0;
    endtask

    task automatic send_frame(input logic [63:0] base, input bit sub);
        for (int k = 0; k < NW; k++) begin
            send_word(base + 64'(k), k == NW - 1, (k == 0) ? sub : 1'b0);
        end
    endtask

    task automatic check_matrix(input string name, input logic [63:0] base);
        for (int k = 0; k < NW; k++) begin
            check($sformatf("%s_w%0d", name, k), opw(k), base + 64'(k));
        end
    endtask

    initial begin
        frames[0] = '{"single",   8,  7, 1'b0, 64'h000, 1'b1, 1'b0};
        frames[1] = '{"short",    6,  5, 1'b0, 64'h020, 1'b0, 1'b1};
        frames[2] = '{"after_sh", 8,  7, 1'b1, 64'h040, 1'b1, 1'b0};
        frames[3] = '{"nolast",   8, -1, 1'b0, 64'h080, 1'b1, 1'b1};
        frames[4] = '{"after_nl", 8,  7, 1'b1, 64'h0C0, 1'b1, 1'b0};

        rst_i = 1'b1; s_data_i = '0; s_valid_i = 1'b0; s_last_i = 1'b0;
        s_sub_i = 1'b0; out_ready_i = 1'b0; flush_i = 1'b0;
        step(); step();
        rst_i = 1'b0;

        check("rst_s_ready",   64'(s_ready_o),   64'd1);
        check("rst_out_valid", 64'(out_valid_o), 64'd0);
        check("rst_err",       64'(err_o),       64'd0);
        check("rst_busy",      64'(busy_o),      64'd0);
        check("rst_sub",       64'(sub_o),       64'd0);
        check("rst_operands",  64'(operands_o != '0), 64'd0);

        // Table frames with out_ready held high.
        out_ready_i = 1'b1;
        foreach (frames[i]) begin
            for (int k = 0; k < frames[i].nwords; k++) begin
                send_word(frames[i].base + 64'(k), k == frames[i].last_idx,
                          (k == 0) ? frames[i].sub : 1'b0);
            end
            check({frames[i].name, "_valid"}, 64'(out_valid_o), 64'(frames[i].exp_valid));
            check({frames[i].name, "_err"},   64'(err_o),       64'(frames[i].exp_err));
            check({frames[i].name, "_busy"},  64'(busy_o),      64'(frames[i].exp_valid));
            if (frames[i].exp_valid) begin
                check({frames[i].name, "_sub"}, 64'(sub_o), 64'(frames[i].sub));
                check_matrix(frames[i].name, frames[i].base);
            end
            step();
            check({frames[i].name, "_valid_next"}, 64'(out_valid_o), 64'd0);
            check({frames[i].name, "_err_next"},   64'(err_o),       64'd0);
            check({frames[i].name, "_busy_next"},  64'(busy_o),      64'd0);
        end

        // Backpressure: two matrices buffer, the third stalls.
        out_ready_i = 1'b0;
        send_frame(64'h100, 1'b0);
        send_frame(64'h200, 1'b0);
        check("bp_s_ready_low", 64'(s_ready_o),   64'd0);
        check("bp_valid",       64'(out_valid_o), 64'd1);
        s_data_i = 64'h300; s_last_i = 1'b0; s_sub_i = 1'b0; s_valid_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("bp_stall%0d_ready", c), 64'(s_ready_o), 64'd0);
            check($sformatf("bp_stall%0d_valid", c), 64'(out_valid_o), 64'd1);
            check($sformatf("bp_stall%0d_w0", c), opw(0), 64'h100);
        end
        check_matrix("bp_a", 64'h100);
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;
        check("bp_ready_back", 64'(s_ready_o),   64'd1);
        check("bp_b_valid",    64'(out_valid_o), 64'd1);
        check("bp_b_w0",       opw(0),           64'h200);
        send_frame(64'h300, 1'b0);
        check("bp_full_again", 64'(s_ready_o), 64'd0);
        check_matrix("bp_b", 64'h200);
        out_ready_i = 1'b1;
        step();
        check("bp_c_valid", 64'(out_valid_o), 64'd1);
        check_matrix("bp_c", 64'h300);
        step();
        check("bp_empty_valid", 64'(out_valid_o), 64'd0);
        check("bp_empty_busy",  64'(busy_o),      64'd0);

        // Flush with one bank full and a partial frame in flight.
        out_ready_i = 1'b0;
        send_frame(64'h500, 1'b0);
        for (int k = 0; k < 3; k++) send_word(64'h600 + 64'(k), 1'b0, 1'b0);
        check("fl_pre_busy", 64'(busy_o), 64'd1);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        check("fl_valid",   64'(out_valid_o), 64'd0);
        check("fl_s_ready", 64'(s_ready_o),   64'd1);
        check("fl_busy",    64'(busy_o),      64'd0);
        check("fl_err",     64'(err_o),       64'd0);
        out_ready_i = 1'b1;
        send_frame(64'h700, 1'b1);
        check("fl_post_valid", 64'(out_valid_o), 64'd1);
        check("fl_post_sub",   64'(sub_o),       64'd1);
        check_matrix("fl_post", 64'h700);
        step();

        // Sub capture: only the first beat's s_sub_i counts.
        out_ready_i = 1'b0;
        for (int k = 0; k < NW; k++) send_word(64'h900 + 64'(k), k == NW - 1, k == 0);
        check("sub_a", 64'(sub_o), 64'd1);
        for (int k = 0; k < NW; k++) send_word(64'hA00 + 64'(k), k == NW - 1, k == 3);
        check("sub_a_held", 64'(sub_o), 64'd1);
        check("sub_a_w0",   opw(0),     64'h900);
        out_ready_i = 1'b1;
        step();
        check("sub_b",       64'(sub_o),       64'd0);
        check("sub_b_valid", 64'(out_valid_o), 64'd1);
        check("sub_b_w0",    opw(0),           64'hA00);
        step();
        check("sub_done_valid", 64'(out_valid_o), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
